// File: rtl/redun_mont_pkg.sv
// Shared definitions for the redundant-form Montgomery datapath: word geometry,
// the field modulus, the redundant operand type and the converter FSM states.
package redun_mont_pkg;

    localparam int NUM_WRDS = 4;
    localparam int WRD_BITS = 4;
    localparam logic [NUM_WRDS*WRD_BITS-1:0] P = 16'hA001;

    // Each redundant word carries one extra bit above the radix.
    typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun0_t;

    // One-hot state encoding for redun_to_bin.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_CARRY = 4'b0010,
        ST_SUB   = 4'b0100,
        ST_DONE  = 4'b1000
    } r2b_state_t;

    // Reference value of a redundant operand: sum of word[i] * 2^(WRD_BITS*i).
    // Intended for testbench use only.
    function automatic logic [NUM_WRDS*WRD_BITS+1:0] from_redun(input redun0_t d);
        logic [NUM_WRDS*WRD_BITS+1:0] acc;
        acc = '0;
        for (int i = 0; i < NUM_WRDS; i++) begin
            acc = acc + ((NUM_WRDS*WRD_BITS+2)'(d[i]) << (WRD_BITS*i));
        end
        return acc;
    endfunction

endpackage

// File: rtl/redun_word_sub.sv
// Single-word subtract with borrow: {bout, diff} = a - b - bin.
module redun_word_sub #(
    parameter int WRD_BITS = 4
) (
    input  logic [WRD_BITS-1:0] i_a,
    input  logic [WRD_BITS-1:0] i_b,
    input  logic                i_bin,
    output logic [WRD_BITS-1:0] o_diff,
    output logic                o_bout
);

    logic [WRD_BITS:0] w_full;

    // One extra bit catches the sign of the result, which is the borrow out.
    always_comb begin
        w_full = {1'b0, i_a} - {1'b0, i_b} - {{WRD_BITS{1'b0}}, i_bin};
        o_diff = w_full[WRD_BITS-1:0];
        o_bout = w_full[WRD_BITS];
    end

endmodule

// File: rtl/redun_to_bin.sv
// Redundant-form to canonical binary converter: word-serial carry resolution
// followed by repeated word-serial conditional subtraction of the modulus.
module redun_to_bin
    import redun_mont_pkg::*;
#(
    parameter int                               NUM_WRDS = redun_mont_pkg::NUM_WRDS,
    parameter int                               WRD_BITS = redun_mont_pkg::WRD_BITS,
    parameter logic [NUM_WRDS*WRD_BITS-1:0]     MODULUS  = redun_mont_pkg::P,
    parameter int                               MAX_SUB  = 4
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  redun0_t                         i_dat,
    input  logic                            i_val,
    output logic                            o_rdy,
    output logic [NUM_WRDS*WRD_BITS-1:0]    o_dat,
    output logic                            o_err,
    output logic                            o_val,
    input  logic                            i_rdy
);

    localparam int IW = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;
    localparam int PW = $clog2(MAX_SUB + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WRDS - 1);

    r2b_state_t                             r_state;
    r2b_state_t                             w_state_next;
    redun0_t                                r_wrd;
    logic [NUM_WRDS-1:0][WRD_BITS-1:0]      r_res;
    logic [NUM_WRDS-2:0][WRD_BITS-1:0]      r_diff;
    logic [1:0]                             r_carry;
    logic [1:0]                             r_ovf;
    logic                                   r_borrow;
    logic [IW-1:0]                          r_idx;
    logic [PW-1:0]                          r_passes;
    logic                                   r_err;

    logic [WRD_BITS-1:0]                    w_mod_wrds [NUM_WRDS];
    logic [WRD_BITS+1:0]                    w_sum;
    logic [WRD_BITS-1:0]                    w_diff;
    logic                                   w_bout;
    logic [2:0]                             w_ext;
    logic                                   w_last;
    logic                                   w_pass_ok;
    logic                                   w_exhaust;

    // Split the modulus into radix words for the word-serial subtractor.
    for (genvar gi = 0; gi < NUM_WRDS; gi++) begin : g_mod
        assign w_mod_wrds[gi] = MODULUS[gi*WRD_BITS +: WRD_BITS];
    end

    redun_word_sub #(.WRD_BITS(WRD_BITS)) u_word_sub (
        .i_a    (r_res[r_idx]),
        .i_b    (w_mod_wrds[r_idx]),
        .i_bin  (r_borrow),
        .o_diff (w_diff),
        .o_bout (w_bout)
    );

    // Carry step, pass acceptance (ext = ovf - borrow >= 0) and pass limit.
    always_comb begin
        w_sum     = (WRD_BITS+2)'(r_wrd[r_idx]) + (WRD_BITS+2)'(r_carry);
        w_ext     = {1'b0, r_ovf} - {2'b00, w_bout};
        w_last    = (r_idx == LAST_IDX);
        w_pass_ok = ~w_ext[2];
        w_exhaust = (r_passes == PW'(MAX_SUB - 1));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and the input-ready strobe.
    always_comb begin
        w_state_next = r_state;
        o_rdy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_rdy = ~i_rst;
                if (i_val) w_state_next = ST_CARRY;
            end
            ST_CARRY: begin
                if (w_last) w_state_next = ST_SUB;
            end
            ST_SUB: begin
                if (w_last && (!w_pass_ok || w_exhaust)) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                if (i_rdy) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture, carry resolution and modulus subtraction passes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrd    <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_carry  <= '0;
            r_ovf    <= '0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
            r_passes <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_val) begin
                        r_wrd   <= i_dat;
                        r_idx   <= '0;
                        r_carry <= '0;
                    end
                end
                ST_CARRY: begin
                    r_res[r_idx] <= w_sum[WRD_BITS-1:0];
                    r_carry      <= w_sum[WRD_BITS+1:WRD_BITS];
                    if (w_last) begin
                        r_ovf    <= w_sum[WRD_BITS+1:WRD_BITS];
                        r_idx    <= '0;
                        r_borrow <= 1'b0;
                        r_passes <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_SUB: begin
                    r_borrow <= w_bout;
                    if (!w_last) begin
                        r_diff[r_idx] <= w_diff;
                        r_idx         <= r_idx + 1'b1;
                    end else if (w_pass_ok) begin
                        // Commit the pass; the last word comes straight from the subtractor.
                        for (int i = 0; i < NUM_WRDS - 1; i++) begin
                            r_res[i] <= r_diff[i];
                        end
                        r_res[NUM_WRDS-1] <= w_diff;
                        r_ovf             <= w_ext[1:0];
                        r_passes          <= r_passes + 1'b1;
                        r_idx             <= '0;
                        r_borrow          <= 1'b0;
                        r_err             <= w_exhaust;
                    end else begin
                        r_err <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_dat = r_res;
    assign o_err = r_err;
    assign o_val = (r_state == ST_DONE);

endmodule

// File: tb/tb_redun_to_bin.sv
// Self-checking bench for redun_to_bin: scoreboarded transactions on a
// MAX_SUB=4 instance and a MAX_SUB=1 instance.
module tb_redun_to_bin;
    import redun_mont_pkg::*;

    typedef struct {
        logic [15:0] dat;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    redun0_t     dat;
    logic        val, rdy, val1, rdy1;
    logic        o_rdy, o_val, o_err, o_rdy1, o_val1, o_err1;
    logic [15:0] o_dat, o_dat1;
    logic        sel_r;
    logic        s_rdy, s_val, s_err;
    logic [15:0] s_dat;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    always #5 clk = ~clk;

    redun_to_bin #(.NUM_WRDS(NUM_WRDS), .WRD_BITS(WRD_BITS), .MODULUS(P), .MAX_SUB(4)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val), .o_rdy(o_rdy),
        .o_dat(o_dat), .o_err(o_err), .o_val(o_val), .i_rdy(rdy)
    );

    redun_to_bin #(.NUM_WRDS(NUM_WRDS), .WRD_BITS(WRD_BITS), .MODULUS(P), .MAX_SUB(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_dat(dat), .i_val(val1), .o_rdy(o_rdy1),
        .o_dat(o_dat1), .o_err(o_err1), .o_val(o_val1), .i_rdy(rdy1)
    );

    assign s_rdy = sel_r ? o_rdy1 : o_rdy;
    assign s_val = sel_r ? o_val1 : o_val;
    assign s_err = sel_r ? o_err1 : o_err;
    assign s_dat = sel_r ? o_dat1 : o_dat;

    function automatic exp_t mk(input logic [15:0] d, input logic e, input int l);
        exp_t r;
        r.dat = d;
        r.err = e;
        r.lat = l;
        return r;
    endfunction

    // Reference behaviour: subtract P while value >= P, up to max_sub passes.
    function automatic exp_t model(input redun0_t d, input int max_sub);
        exp_t        r;
        logic [17:0] v;
        int          k;
        v = from_redun(d);
        k = 0;
        while (k < max_sub && v >= 18'(P)) begin
            v = v - 18'(P);
            k++;
        end
        r.dat = v[15:0];
        r.err = (k == max_sub);
        r.lat = r.err ? (max_sub + 1) * NUM_WRDS + 1 : (k + 2) * NUM_WRDS + 1;
        return r;
    endfunction

    task automatic set_val(input logic b);
        if (sel_r) val1 = b; else val = b;
    endtask

    task automatic set_rdy(input logic b);
        if (sel_r) rdy1 = b; else rdy = b;
    endtask

    // One transaction on the selected instance with 'hold' cycles of backpressure.
    task automatic transact(input redun0_t d, input exp_t e, input int hold);
        exp_t ex;
        int   cyc;
        cyc = 0;
        while (!s_rdy && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!s_rdy) begin
            n_bad++;
            $display("FAIL accept_wait: o_rdy=%b required 1", s_rdy);
        end
        dat = d;
        set_val(1'b1);
        sb_q.push_back(e);
        @(negedge clk);
        set_val(1'b0);
        cyc = 1;
        while (!s_val && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        ex = sb_q.pop_front();
        n_txn++;
        n_cmp++;
        if (!s_val) begin
            n_bad++;
            $display("FAIL out_timeout: o_val=%b after %0d cycles required 1", s_val, cyc);
            return;
        end
        $display("txn %0d: in=%h dat=%h err=%b lat=%0d", n_txn, d, s_dat, s_err, cyc);
        n_cmp++;
        if (cyc !== ex.lat) begin
            n_bad++;
            $display("FAIL latency: got %0d required %0d", cyc, ex.lat);
        end
        n_cmp++;
        if (s_dat !== ex.dat) begin
            n_bad++;
            $display("FAIL o_dat: got %h required %h", s_dat, ex.dat);
        end
        n_cmp++;
        if (s_err !== ex.err) begin
            n_bad++;
            $display("FAIL o_err: got %b required %b", s_err, ex.err);
        end
        for (int i = 0; i < hold; i++) begin
            if (i == 2) begin
                dat = redun0_t'($urandom);
                set_val(1'b1);
            end
            @(negedge clk);
            set_val(1'b0);
            n_cmp++;
            if (s_val !== 1'b1 || s_dat !== ex.dat || s_err !== ex.err || s_rdy !== 1'b0) begin
                n_bad++;
                $display("FAIL hold: val=%b dat=%h err=%b rdy=%b required 1 %h %b 0",
                         s_val, s_dat, s_err, s_rdy, ex.dat, ex.err);
            end
        end
        set_rdy(1'b1);
        @(negedge clk);
        set_rdy(1'b0);
        n_cmp++;
        if (s_val !== 1'b0 || s_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL post_handshake: val=%b rdy=%b required 0 1", s_val, s_rdy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (o_val !== 1'b0 || o_err !== 1'b0 || o_dat !== 16'h0 || o_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: val=%b err=%b dat=%h rdy=%b required 0 0 0000 0",
                     o_val, o_err, o_dat, o_rdy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_rdy !== 1'b1 || o_rdy1 !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release: rdy=%b rdy1=%b required 1 1", o_rdy, o_rdy1);
        end
    endtask

    task automatic test_zero();
        sel_r = 1'b0;
        transact('0, mk(16'h0000, 1'b0, 9), 0);
    endtask

    task automatic test_carry_word();
        redun0_t d;
        d = '0;
        d[0] = 5'h1F;
        sel_r = 1'b0;
        transact(d, mk(16'h001F, 1'b0, 9), 0);
    endtask

    task automatic test_multi_pass();
        redun0_t d;
        for (int i = 0; i < NUM_WRDS; i++) d[i] = 5'h1F;
        sel_r = 1'b0;
        transact(d, mk(16'h310C, 1'b0, 21), 0);
    endtask

    task automatic test_max_sub1();
        redun0_t d;
        for (int i = 0; i < NUM_WRDS; i++) d[i] = 5'h1F;
        sel_r = 1'b1;
        transact(d, mk(16'h710E, 1'b1, 9), 0);
        sel_r = 1'b0;
    endtask

    task automatic test_modulus();
        redun0_t d;
        d = '0;
        d[0] = 5'h01;
        d[3] = 5'h0A;
        sel_r = 1'b0;
        transact(d, mk(16'h0000, 1'b0, 13), 0);
        d = '0;
        d[0] = 5'h02;
        d[3] = 5'h14;
        transact(d, mk(16'h0000, 1'b0, 17), 0);
    endtask

    task automatic test_backpressure();
        redun0_t d;
        d = '0;
        d[1] = 5'h1C;
        d[3] = 5'h0B;
        sel_r = 1'b0;
        transact(d, model(d, 4), 5);
        d[2] = 5'h13;
        transact(d, model(d, 4), 0);
    endtask

    task automatic test_back_to_back();
        redun0_t d;
        sel_r = 1'b0;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NUM_WRDS; i++) d[i] = 5'($urandom_range(0, 31));
            transact(d, model(d, 4), n % 2);
        end
    endtask

    // Start a transaction, assert reset after 'cyc' cycles, then check recovery.
    task automatic test_reset_abort(input int cyc);
        redun0_t d;
        for (int i = 0; i < NUM_WRDS; i++) d[i] = 5'h1F;
        sel_r = 1'b0;
        dat = d;
        val = 1'b1;
        @(negedge clk);
        val = 1'b0;
        repeat (cyc - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_val !== 1'b0 || o_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_%0d: val=%b rdy=%b required 0 0", cyc, o_val, o_rdy);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (o_val !== 1'b0 || o_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_idle_%0d: val=%b rdy=%b required 0 1", cyc, o_val, o_rdy);
        end
        d[0] = 5'($urandom_range(0, 31));
        d[2] = 5'($urandom_range(0, 31));
        transact(d, model(d, 4), 0);
    endtask

    initial begin
        val   = 1'b0;
        val1  = 1'b0;
        rdy   = 1'b0;
        rdy1  = 1'b0;
        dat   = '0;
        sel_r = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        test_reset();
        test_zero();
        test_carry_word();
        test_multi_pass();
        test_max_sub1();
        test_modulus();
        test_backpressure();
        test_back_to_back();
        test_reset_abort(2);
        test_reset_abort(7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/redun_to_bin.md
# redun_to_bin

Converts a redundant-form result from the Montgomery squaring datapath into a fully carry-resolved, canonical binary residue in [0, MODULUS). It sits on the output side of the squarer. It accepts one redun0_t value per transaction and resolves the per-word carries word-serially. It then applies repeated conditional subtraction of the modulus and presents the result on a valid/ready output port.

## Interface
- NUM_WRDS, default redun_mont_pkg::NUM_WRDS: number of redundant words.
- WRD_BITS, default redun_mont_pkg::WRD_BITS: radix bits per word. Each input word is WRD_BITS+1 bits wide.
- MODULUS, default redun_mont_pkg::P: reduction modulus, NUM_WRDS*WRD_BITS bits.
- MAX_SUB, default 4: maximum number of accepted subtraction passes.

Ports:
- i_clk, in, 1: clock.
- i_rst, in, 1: reset, synchronous, active-high.
- i_dat, in, redun0_t: redundant input. Value = Σ i_dat[i]·2^(WRD_BITS·i).
- i_val, in, 1: input valid.
- o_rdy, out, 1: input ready.
- o_dat, out, NUM_WRDS*WRD_BITS: canonical result.
- o_err, out, 1: MAX_SUB was exhausted; o_dat may not be fully reduced.
- o_val, out, 1: output valid.
- i_rdy, in, 1: downstream ready.

## Operation
States are IDLE, CARRY, SUB and DONE, encoded one-hot.

IDLE:
- o_rdy=1.
- On i_val: capture i_dat into the word register, set idx=0 and carry=0, go to CARRY.

CARRY, one word per cycle:
- s = word[idx] + carry.
- res[idx] = s[WRD_BITS-1:0].
- carry = s >> WRD_BITS. carry is 2 bits; its maximum value is 2.
- At idx=NUM_WRDS-1: ovf = final carry (2 bits). Then go to SUB with idx=0, borrow=0, passes=0.

SUB, one word per cycle:
- diff[idx] = res[idx] − MODULUS word idx − borrow. The per-word borrow is registered.
- At the last word, compute ext = ovf − borrow.
- If ext ≥ 0, the pass is accepted:
  - res ← diff, ovf ← ext, passes++.
  - If passes reaches MAX_SUB, set o_err=1 and go to DONE.
  - Otherwise start a new pass: idx=0, borrow=0.
- If ext < 0, the pass is rejected: res is unchanged, o_err=0, go to DONE.

DONE:
- o_val=1 and o_dat=res.
- On i_rdy: go to IDLE.

Rules:
- o_rdy=0 in every state except IDLE. i_val outside IDLE is ignored.
- o_dat and o_err are registered and held stable while o_val=1 and i_rdy=0.
- Arithmetic is unsigned. The full value during reduction is {ovf, res}, NUM_WRDS*WRD_BITS+2 bits.
- An input value equal to a multiple of MODULUS, including MODULUS itself, yields 0.
- Reset: state=IDLE, o_val=0, o_err=0, o_dat=0, all internal registers 0. o_rdy=0 while i_rst is high.
- Reset asserted in any state aborts the transaction; nothing is output.

## Timing
- Acceptance handshake at edge 0.
- CARRY occupies cycles 1..N, where N=NUM_WRDS.
- SUB occupies cycles N+1..(k+2)·N, where k is the number of accepted passes and one rejecting pass follows them.
- o_val rises in cycle (k+2)·N+1.
- If MAX_SUB is exhausted, there is no rejecting pass and o_val rises in cycle (MAX_SUB+1)·N+1.
- Output handshake (o_val & i_rdy) at cycle t gives o_val=0 and o_rdy=1 at cycle t+1. The earliest next acceptance is at cycle t+1.
- Throughput: one transaction per latency + 1 cycles, at minimum.
- All outputs come from registers. No combinational path runs from any input to any output except the state-decoded o_rdy.

## Structure
redun_mont_pkg (already shared) provides:
- NUM_WRDS, WRD_BITS, P, redun0_t.
- A new from_redun reference function, for use by the bench only.

Sub-module:
- redun_word_sub: a combinational single-word subtract-with-borrow (a − b − bin → diff, bout).
- The CARRY step is a simple adder, kept inline.

## Test plan
All scenarios use NUM_WRDS=4, WRD_BITS=4, MODULUS=16'hA001 (40961).
- All-zero input → o_dat=0, o_err=0, o_val rises 9 cycles after acceptance.
- Word0=5'h1F, others 0 → o_dat=16'h001F (carry resolves into word1), latency 9.
- All words 5'h1F (value 135439 = 0x2110F) with MAX_SUB=4 → three passes accepted, fourth rejected. Expect o_dat=16'h310C (12556), o_err=0, latency 21.
- Same input with MAX_SUB=1 → o_dat=16'h710E (low bits of 94478), o_err=1, latency 9.
- Input words {1,0,0,0xA} (=MODULUS) → o_dat=0, o_err=0.
- Backpressure: hold i_rdy=0 for 5 cycles in DONE → o_dat, o_err and o_val are stable and o_rdy=0. Pulse i_val during the hold → it is ignored. After the handshake, the next transaction is accepted and correct.
- Reset mid-CARRY and mid-SUB → o_val=0 the next cycle and the block returns to IDLE. A following transaction matches from_redun mod MODULUS.
